// File: rtl/data_memory_pipe_pkg.sv
// -----------------------------------------------------------------------------
// data_memory_pipe_pkg
// Shared definitions for the pipelined data memory:
//   RW_WRITE / RW_READ : encoding of the rw_enable request type (0 = write, 1 = load)
//   dmp_state_e        : zero-fill / run state machine encoding
//   dmp_log2()         : ceil(log2(depth)), used to size the word index
// -----------------------------------------------------------------------------
package data_memory_pipe_pkg;

    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } dmp_state_e;

    // Smallest r with 2**r >= depth; exact log2 for the power-of-two depths used here.
    function automatic int dmp_log2(input int depth);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'd1 << i) < depth) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/data_memory_rd_pipe.sv
// -----------------------------------------------------------------------------
// data_memory_rd_pipe
// Delay line of STAGES register stages for the load return path.
// Each stage carries valid, data and err. Data is only captured when the
// incoming valid is set, so the output word holds the last load value between
// pulses; err is forced low whenever valid is low. STAGES = 0 is a wire.
// Ports:
//   clk, rst (async, active high: clears every stage, dropping loads in flight)
//   valid_i / data_i / err_i : stage-0 load result
//   valid_o / data_o / err_o : delayed load result
// -----------------------------------------------------------------------------
module data_memory_rd_pipe #(
    parameter int DATA_W = 32,
    parameter int STAGES = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              err_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic              err_o
);

    generate
        if (STAGES == 0) begin : g_bypass
            assign valid_o = valid_i;
            assign data_o  = data_i;
            assign err_o   = err_i;

            logic unused_clk;
            assign unused_clk = clk ^ rst;
        end else begin : g_delay
            logic [STAGES-1:0] vld_q;
            logic [STAGES-1:0] err_q;
            logic [DATA_W-1:0] dat_q [STAGES];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    vld_q <= '0;
                    err_q <= '0;
                    for (int i = 0; i < STAGES; i++) begin
                        dat_q[i] <= '0;
                    end
                end else begin
                    vld_q[0] <= valid_i;
                    err_q[0] <= valid_i & err_i;
                    if (valid_i) begin
                        dat_q[0] <= data_i;
                    end
                    for (int i = 1; i < STAGES; i++) begin
                        vld_q[i] <= vld_q[i-1];
                        err_q[i] <= vld_q[i-1] & err_q[i-1];
                        if (vld_q[i-1]) begin
                            dat_q[i] <= dat_q[i-1];
                        end
                    end
                end
            end

            assign valid_o = vld_q[STAGES-1];
            assign err_o   = err_q[STAGES-1];
            assign data_o  = dat_q[STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/data_memory_pipe.sv
// -----------------------------------------------------------------------------
// data_memory_pipe
// Clocked word-addressed data memory with per-byte write enables, RD_LAT-cycle
// registered loads, valid/ready acceptance and a post-reset zero-fill.
// After reset the INIT state walks idx 0..DEPTH-1 writing zeros (mem_ready low),
// then RUN accepts one request per cycle forever.
// Ports:
//   clk, rst (async, active high)
//   mem_enable  : request valid      rw_enable : 0 = write, 1 = load
//   address     : word address       data_in   : write data
//   byte_en     : per-byte write enable (ignored on loads)
//   mem_ready   : request accepted when mem_enable & mem_ready
//   data_out    : load data, held between data_valid pulses
//   data_valid  : one-cycle load-return pulse
//   oob_err     : out-of-range pulse (load: with data_valid; write: cycle after accept)
// Optional feature: define DATA_MEMORY_PIPE_OOB_CHECK_EN to drop out-of-range
// writes and zero out-of-range loads with oob_err; otherwise addresses wrap
// modulo DEPTH and oob_err is constant 0.
// -----------------------------------------------------------------------------
module data_memory_pipe
    import data_memory_pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 1024,
    parameter int RD_LAT = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                mem_enable,
    input  logic                rw_enable,
    input  logic [ADDR_W-1:0]   address,
    input  logic [DATA_W-1:0]   data_in,
    input  logic [DATA_W/8-1:0] byte_en,
    output logic                mem_ready,
    output logic [DATA_W-1:0]   data_out,
    output logic                data_valid,
    output logic                oob_err
);

    localparam int AW = dmp_log2(DEPTH);
    localparam int NB = DATA_W / 8;

    // ---------------------------------------------------------------- FSM
    dmp_state_e     state_q, state_d;
    logic [AW-1:0]  idx_q, idx_d;
    logic           init_we;
    logic           ready_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_INIT;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            ST_INIT: begin
                idx_d = idx_q + 1'b1;
                if (idx_q == AW'(DEPTH - 1)) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_comb begin
        init_we = 1'b0;
        ready_c = 1'b0;
        case (state_q)
            ST_INIT: init_we = 1'b1;
            default: ready_c = 1'b1;
        endcase
    end

    assign mem_ready = ready_c;

    // ---------------------------------------------------------- requests
    logic          accept, wr_acc, rd_acc;
    logic [AW-1:0] addr_idx;
    logic          req_oob;

    assign accept   = mem_enable & ready_c;
    assign wr_acc   = accept & (rw_enable == RW_WRITE);
    assign rd_acc   = accept & (rw_enable == RW_READ);
    assign addr_idx = address[AW-1:0];

`ifdef DATA_MEMORY_PIPE_OOB_CHECK_EN
    generate
        if (ADDR_W > AW) begin : g_oob
            assign req_oob = |address[ADDR_W-1:AW];
        end else begin : g_no_oob
            assign req_oob = 1'b0;
        end
    endgenerate
`else
    // Upper address bits are discarded, so accesses wrap modulo DEPTH.
    assign req_oob = 1'b0;
    generate
        if (ADDR_W > AW) begin : g_wrap
            logic unused_addr_hi;
            assign unused_addr_hi = ^address[ADDR_W-1:AW];
        end
    endgenerate
`endif

    // Single write port shared between the zero-fill walk and normal writes.
    logic [AW-1:0]     wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [NB-1:0]     wr_be;

    always_comb begin
        wr_addr = addr_idx;
        wr_data = data_in;
        wr_be   = '0;
        if (init_we) begin
            wr_addr = idx_q;
            wr_data = '0;
            wr_be   = '1;
        end else if (wr_acc && !req_oob) begin
            wr_be   = byte_en;
        end
    end

    // ------------------------------------------------- byte-lane storage
    // One RAM per byte lane keeps each lane a plain single-write-port array.
    logic [DATA_W-1:0] rd_raw;

    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_lane
            logic [7:0] mem_q [DEPTH];
            logic [7:0] rd_byte_q;

            always_ff @(posedge clk) begin
                if (wr_be[gi]) begin
                    mem_q[wr_addr] <= wr_data[gi*8 +: 8];
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rd_byte_q <= '0;
                end else if (rd_acc) begin
                    rd_byte_q <= mem_q[addr_idx];
                end
            end

            assign rd_raw[gi*8 +: 8] = rd_byte_q;
        end
    endgenerate

    // ----------------------------------------------------- stage 0 flags
    // rd_zero_q is held with the read register (not pulsed) so that an
    // out-of-range load keeps returning 0 while data_out is being held.
    logic rd_vld_q, rd_zero_q, wr_err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_vld_q  <= 1'b0;
            rd_zero_q <= 1'b0;
            wr_err_q  <= 1'b0;
        end else begin
            rd_vld_q <= rd_acc;
            wr_err_q <= wr_acc & req_oob;
            if (rd_acc) begin
                rd_zero_q <= req_oob;
            end
        end
    end

    logic [DATA_W-1:0] stage0_data;
    logic              stage0_err;
    logic              pipe_err;

    assign stage0_data = rd_zero_q ? '0 : rd_raw;
    assign stage0_err  = rd_vld_q & rd_zero_q;

    data_memory_rd_pipe #(
        .DATA_W (DATA_W),
        .STAGES (RD_LAT - 1)
    ) u_rd_pipe (
        .clk     (clk),
        .rst     (rst),
        .valid_i (rd_vld_q),
        .data_i  (stage0_data),
        .err_i   (stage0_err),
        .valid_o (data_valid),
        .data_o  (data_out),
        .err_o   (pipe_err)
    );

`ifdef DATA_MEMORY_PIPE_OOB_CHECK_EN
    assign oob_err = pipe_err | wr_err_q;
`else
    assign oob_err = 1'b0;
    logic unused_err;
    assign unused_err = pipe_err ^ wr_err_q;
`endif

endmodule

// File: tb/tb_data_memory_pipe.sv
// -----------------------------------------------------------------------------
// tb_data_memory_pipe
// Two instances (RD_LAT = 3 and RD_LAT = 2, DEPTH = 16) share clock, reset and
// request inputs; each checks its own return timing. Directed vectors with
// hand-computed results. Out-of-range expectations follow
// DATA_MEMORY_PIPE_OOB_CHECK_EN.
// -----------------------------------------------------------------------------
module tb_data_memory_pipe;
    import data_memory_pipe_pkg::*;

`ifdef DATA_MEMORY_PIPE_OOB_CHECK_EN
    localparam bit OOB_EN = 1'b1;
`else
    localparam bit OOB_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_enable = 1'b0;
    logic        rw_enable = RW_READ;
    logic [7:0]  address = '0;
    logic [31:0] data_in = '0;
    logic [3:0]  byte_en = '0;

    logic        rdy3, dv3, err3;
    logic [31:0] dout3;
    logic        rdy2, dv2, err2;
    logic [31:0] dout2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    data_memory_pipe #(.DATA_W(32), .ADDR_W(8), .DEPTH(16), .RD_LAT(3)) u_dut_l3 (
        .clk(clk), .rst(rst), .mem_enable(mem_enable), .rw_enable(rw_enable),
        .address(address), .data_in(data_in), .byte_en(byte_en),
        .mem_ready(rdy3), .data_out(dout3), .data_valid(dv3), .oob_err(err3)
    );

    data_memory_pipe #(.DATA_W(32), .ADDR_W(8), .DEPTH(16), .RD_LAT(2)) u_dut_l2 (
        .clk(clk), .rst(rst), .mem_enable(mem_enable), .rw_enable(rw_enable),
        .address(address), .data_in(data_in), .byte_en(byte_en),
        .mem_ready(rdy2), .data_out(dout2), .data_valid(dv2), .oob_err(err2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [7:0] a, input logic [31:0] d,
                            input logic [3:0] be, input logic exp_oob);
        mem_enable = 1'b1;
        rw_enable  = RW_WRITE;
        address    = a;
        data_in    = d;
        byte_en    = be;
        tick();
        mem_enable = 1'b0;
        $display("[TB] write addr=%0d data=0x%08h be=%b", a, d, be);
        chk("wr_oob_l3", {31'd0, err3}, {31'd0, exp_oob});
        chk("wr_oob_l2", {31'd0, err2}, {31'd0, exp_oob});
        chk("wr_dv_l3", {31'd0, dv3}, 32'd0);
    endtask

    // Accept a load, then follow both instances through their return cycles.
    task automatic load_check(input logic [7:0] a, input logic [31:0] exp_d, input logic exp_e);
        mem_enable = 1'b1;
        rw_enable  = RW_READ;
        address    = a;
        tick();
        mem_enable = 1'b0;
        chk("ld_early_dv_l2", {31'd0, dv2}, 32'd0);
        chk("ld_early_dv_l3", {31'd0, dv3}, 32'd0);
        tick();
        chk("ld_dv_l2", {31'd0, dv2}, 32'd1);
        chk("ld_data_l2", dout2, exp_d);
        chk("ld_oob_l2", {31'd0, err2}, {31'd0, exp_e});
        chk("ld_mid_dv_l3", {31'd0, dv3}, 32'd0);
        tick();
        chk("ld_dv_l3", {31'd0, dv3}, 32'd1);
        chk("ld_data_l3", dout3, exp_d);
        chk("ld_oob_l3", {31'd0, err3}, {31'd0, exp_e});
        chk("ld_after_dv_l2", {31'd0, dv2}, 32'd0);
        chk("ld_hold_l2", dout2, exp_d);
        $display("[TB] load  addr=%0d data=0x%08h oob=%0d", a, dout3, err3);
    endtask

    task automatic release_and_fill();
        rst = 1'b0;
        repeat (15) tick();
        chk("fill_rdy15_l3", {31'd0, rdy3}, 32'd0);
        chk("fill_rdy15_l2", {31'd0, rdy2}, 32'd0);
        tick();
        chk("fill_rdy16_l3", {31'd0, rdy3}, 32'd1);
        chk("fill_rdy16_l2", {31'd0, rdy2}, 32'd1);
        $display("[TB] zero-fill done");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---- reset values
        rst = 1'b1;
        tick();
        tick();
        chk("rst_rdy", {31'd0, rdy3}, 32'd0);
        chk("rst_dv", {31'd0, dv3}, 32'd0);
        chk("rst_dout", dout3, 32'd0);
        chk("rst_oob", {31'd0, err3}, 32'd0);
        chk("rst_dout_l2", dout2, 32'd0);

        // ---- zero-fill, then a load of untouched memory
        release_and_fill();
        load_check(8'd5, 32'h0000_0000, 1'b0);

        // ---- byte enables
        do_write(8'd3, 32'hAABB_CCDD, 4'b1111, 1'b0);
        do_write(8'd3, 32'h1122_3344, 4'b0101, 1'b0);
        load_check(8'd3, 32'hAA22_CC44, 1'b0);
        do_write(8'd3, 32'hFFFF_FFFF, 4'b0000, 1'b0);
        load_check(8'd3, 32'hAA22_CC44, 1'b0);

        // ---- read-after-write on consecutive cycles
        do_write(8'd7, 32'h0000_0005, 4'b1111, 1'b0);
        load_check(8'd7, 32'h0000_0005, 1'b0);

        // ---- streaming loads 0,1,2
        do_write(8'd0, 32'd0, 4'b1111, 1'b0);
        do_write(8'd1, 32'd1, 4'b1111, 1'b0);
        do_write(8'd2, 32'd2, 4'b1111, 1'b0);
        mem_enable = 1'b1;
        rw_enable  = RW_READ;
        address    = 8'd0;
        tick();                                     // cycle A+1
        chk("st_a1_dv_l3", {31'd0, dv3}, 32'd0);
        chk("st_a1_dv_l2", {31'd0, dv2}, 32'd0);
        address = 8'd1;
        tick();                                     // cycle A+2
        chk("st_a2_dv_l3", {31'd0, dv3}, 32'd0);
        chk("st_a2_dv_l2", {31'd0, dv2}, 32'd1);
        chk("st_a2_d_l2", dout2, 32'd0);
        address = 8'd2;
        tick();                                     // cycle A+3
        mem_enable = 1'b0;
        chk("st_a3_dv_l3", {31'd0, dv3}, 32'd1);
        chk("st_a3_d_l3", dout3, 32'd0);
        chk("st_a3_d_l2", dout2, 32'd1);
        tick();                                     // cycle A+4
        chk("st_a4_dv_l3", {31'd0, dv3}, 32'd1);
        chk("st_a4_d_l3", dout3, 32'd1);
        chk("st_a4_d_l2", dout2, 32'd2);
        tick();                                     // cycle A+5
        chk("st_a5_dv_l3", {31'd0, dv3}, 32'd1);
        chk("st_a5_d_l3", dout3, 32'd2);
        chk("st_a5_dv_l2", {31'd0, dv2}, 32'd0);
        tick();                                     // cycle A+6
        chk("st_a6_dv_l3", {31'd0, dv3}, 32'd0);
        chk("st_a6_hold_l3", dout3, 32'd2);
        $display("[TB] stream loads 0,1,2 done");

        // ---- out of range (address 20 on DEPTH 16)
        do_write(8'd4, 32'h0000_0012, 4'b1111, 1'b0);
        do_write(8'd20, 32'h0000_00FF, 4'b1111, OOB_EN);
        tick();
        chk("oob_wr_pulse_end", {31'd0, err3}, 32'd0);
        load_check(8'd4, OOB_EN ? 32'h0000_0012 : 32'h0000_00FF, 1'b0);
        load_check(8'd20, OOB_EN ? 32'h0000_0000 : 32'h0000_00FF, OOB_EN);

        // ---- reset with loads in flight
        mem_enable = 1'b1;
        rw_enable  = RW_READ;
        address    = 8'd3;
        tick();                                     // load accepted
        mem_enable = 1'b0;
        rst = 1'b1;
        #1;
        chk("fl_dv_l2", {31'd0, dv2}, 32'd0);
        chk("fl_dv_l3", {31'd0, dv3}, 32'd0);
        chk("fl_dout_l3", dout3, 32'd0);
        chk("fl_rdy", {31'd0, rdy3}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("fl_dv_rst_l2", {31'd0, dv2}, 32'd0);
            chk("fl_dv_rst_l3", {31'd0, dv3}, 32'd0);
        end
        $display("[TB] reset during load in flight");
        release_and_fill();
        load_check(8'd3, 32'h0000_0000, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
